// File: rtl/merge_tree_pkg.sv
// ============================================================================
//  Module   : merge_tree_pkg
//  Brief    : Shared FSM encoding and byte-enable helper for the merge tree root.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package merge_tree_pkg;

    localparam int c_KEEP_MAX = 128;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_RUN   = 2'd1,
        FSM_FLUSH = 2'd2
    } fsm_t;

    // Low k*bytes_per_rec bits set; callers truncate to their own tkeep width.
    function automatic logic [c_KEEP_MAX-1:0] keep_mask(input int k, input int bytes_per_rec);
        logic [c_KEEP_MAX-1:0] m;
        int                    nb;
        nb = k * bytes_per_rec;
        m  = '0;
        for (int i = 0; i < c_KEEP_MAX; i++) begin
            if (i < nb) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/merge_tree_axis_out_reg.sv
// ============================================================================
//  Module   : merge_tree_axis_out_reg
//  Brief    : One-entry AXI-Stream output register with load/valid/ready.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module merge_tree_axis_out_reg #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [KEEP_WIDTH-1:0] i_keep,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [KEEP_WIDTH-1:0] o_keep,
    output logic                  o_last
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [KEEP_WIDTH-1:0] r_keep;
    logic                  r_last;

    // Payload only changes on load, so it stays stable while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;

endmodule

`default_nettype wire

// File: rtl/merge_tree_axis_packer.sv
// ============================================================================
//  Module   : merge_tree_axis_packer
//  Brief    : Packs a run of merge-tree root records into AXI-Stream beats.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module merge_tree_axis_packer
    import merge_tree_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH  = 512,
    parameter int RECORD_DATA_WIDTH = 32,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic [CNT_WIDTH-1:0]            i_num_records,
    input  logic [RECORD_DATA_WIDTH-1:0]    i_data,
    input  logic                            i_data_vld,
    output logic                            o_read,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic [AXIS_TDATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int RECORDS_PER_BEAT = AXIS_TDATA_WIDTH / RECORD_DATA_WIDTH;
    localparam int c_KEEP_W         = AXIS_TDATA_WIDTH / 8;
    localparam int c_SLOT_W         = (RECORDS_PER_BEAT > 1) ? $clog2(RECORDS_PER_BEAT) : 1;

    fsm_t                        r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]        r_remaining;
    logic [c_SLOT_W-1:0]         r_slot_cnt;
    logic [AXIS_TDATA_WIDTH-1:0] r_asm;
    logic                        r_done, w_done_nxt;

    logic                        w_last_rec, w_full, w_complete, w_stall, w_load;
    logic [AXIS_TDATA_WIDTH-1:0] w_beat;
    logic [c_KEEP_W-1:0]         w_keep;

    assign w_last_rec = (r_remaining == CNT_WIDTH'(1));
    assign w_full     = (r_slot_cnt == c_SLOT_W'(RECORDS_PER_BEAT - 1));
    assign w_complete = w_last_rec | w_full;
    // A handshake this cycle frees the output register, so only a held beat stalls.
    assign w_stall    = w_complete & m_axis_tvalid & ~m_axis_tready;
    assign o_read     = (r_state == FSM_RUN) & i_data_vld & ~w_stall;
    assign w_load     = o_read & w_complete;
    assign o_busy     = (r_state != FSM_IDLE);
    assign o_done     = r_done;

    // Slots above slot_cnt are still zero, which gives the zero fill of a partial beat.
    always_comb begin
        w_beat = r_asm;
        for (int s = 0; s < RECORDS_PER_BEAT; s++) begin
            if (r_slot_cnt == c_SLOT_W'(s)) w_beat[s*RECORD_DATA_WIDTH +: RECORD_DATA_WIDTH] = i_data;
        end
    end

    assign w_keep = c_KEEP_W'(keep_mask(int'({{(32-c_SLOT_W){1'b0}}, r_slot_cnt}) + 1,
                                        RECORD_DATA_WIDTH / 8));

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            FSM_IDLE: begin
                if (i_start) begin
                    if (i_num_records != '0) w_state_nxt = FSM_RUN;
                    else                     w_done_nxt  = 1'b1;
                end
            end
            FSM_RUN: begin
                if (o_read && w_last_rec) w_state_nxt = FSM_FLUSH;
            end
            FSM_FLUSH: begin
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    w_state_nxt = FSM_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = FSM_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= FSM_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_remaining <= '0;
            r_slot_cnt  <= '0;
            r_asm       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (r_state == FSM_IDLE && i_start) r_remaining <= i_num_records;
            else if (o_read)                    r_remaining <= r_remaining - CNT_WIDTH'(1);
            if (o_read) begin
                if (w_complete) begin
                    r_asm      <= '0;
                    r_slot_cnt <= '0;
                end else begin
                    r_asm      <= w_beat;
                    r_slot_cnt <= r_slot_cnt + c_SLOT_W'(1);
                end
            end
        end
    end

    merge_tree_axis_out_reg #(
        .DATA_WIDTH (AXIS_TDATA_WIDTH),
        .KEEP_WIDTH (c_KEEP_W)
    ) u_out_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_data  (w_beat),
        .i_keep  (w_keep),
        .i_last  (w_last_rec),
        .i_ready (m_axis_tready),
        .o_valid (m_axis_tvalid),
        .o_data  (m_axis_tdata),
        .o_keep  (m_axis_tkeep),
        .o_last  (m_axis_tlast)
    );

endmodule

`default_nettype wire

// File: tb/tb_merge_tree_axis_packer.sv
// ============================================================================
//  Module   : tb_merge_tree_axis_packer
//  Brief    : Scoreboard bench for merge_tree_axis_packer at default widths.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_merge_tree_axis_packer;

    localparam int AXW = 512;
    localparam int RW  = 32;
    localparam int CW  = 32;
    localparam int RPB = AXW / RW;
    localparam int KW  = AXW / 8;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic           i_start;
    logic [CW-1:0]  i_num_records;
    logic [RW-1:0]  i_data;
    logic           i_data_vld;
    logic           o_read;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic [AXW-1:0] m_axis_tdata;
    logic [KW-1:0]  m_axis_tkeep;
    logic           m_axis_tlast;
    logic           o_busy;
    logic           o_done;

    typedef struct {
        logic [AXW-1:0] d;
        logic [KW-1:0]  k;
        logic           l;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    reads_cnt = 0;
    time   last_hs_t = 0;

    always #5 i_clk = ~i_clk;

    merge_tree_axis_packer #(
        .AXIS_TDATA_WIDTH  (AXW),
        .RECORD_DATA_WIDTH (RW),
        .CNT_WIDTH         (CW)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_num_records (i_num_records),
        .i_data        (i_data),
        .i_data_vld    (i_data_vld),
        .o_read        (o_read),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    // Scoreboard: every handshaken beat is checked against the oldest expected beat.
    always @(negedge i_clk) begin
        if (!i_rst && m_axis_tvalid && m_axis_tready) begin
            beat_t e;
            n_tests++;
            last_hs_t = $time;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got tdata=%h tkeep=%h tlast=%b, required no beat",
                         m_axis_tdata, m_axis_tkeep, m_axis_tlast);
            end else begin
                e = exp_q.pop_front();
                if (m_axis_tdata !== e.d || m_axis_tkeep !== e.k || m_axis_tlast !== e.l) begin
                    n_fail++;
                    $display("FAIL beat_content: got tdata=%h tkeep=%h tlast=%b required tdata=%h tkeep=%h tlast=%b",
                             m_axis_tdata, m_axis_tkeep, m_axis_tlast, e.d, e.k, e.l);
                end
            end
        end
    end

    task automatic push_run(input int n, input int base);
        beat_t b;
        int    idx = 0;
        while (idx < n) begin
            b.d = '0;
            b.k = '0;
            for (int s = 0; s < RPB && idx < n; s++) begin
                b.d[s*RW +: RW] = RW'(base + idx);
                b.k[s*4 +: 4]   = 4'hF;
                idx++;
            end
            b.l = (idx == n);
            exp_q.push_back(b);
        end
    endtask

    task automatic do_start(input int n);
        i_start       = 1'b1;
        i_num_records = CW'(n);
        @(posedge i_clk); #1;
        i_start       = 1'b0;
    endtask

    // Presents records base.. until n are popped; reports cycles used.
    task automatic feed(input int n, input int base, input bit gappy, input int bound, output int cycles);
        int idx = 0;
        bit ph  = 1'b1;
        bit bad = 1'b0;
        cycles = 0;
        while (idx < n && cycles < bound) begin
            i_data     = RW'(base + idx);
            i_data_vld = gappy ? ph : 1'b1;
            @(negedge i_clk);
            if (o_read && !i_data_vld) bad = 1'b1;
            if (o_read) begin
                idx++;
                reads_cnt++;
            end
            @(posedge i_clk); #1;
            ph = ~ph;
            cycles++;
        end
        i_data_vld = 1'b0;
        n_tests++;
        if (idx != n || bad) begin
            n_fail++;
            $display("FAIL feed: accepted %0d records (read without valid=%0b), required %0d", idx, bad, n);
        end
    endtask

    task automatic wait_done(input bit chk_lat);
        int c = 0;
        @(negedge i_clk);
        while (!o_done && c < 500) begin
            @(negedge i_clk);
            c++;
        end
        n_tests++;
        if (!o_done) begin
            n_fail++;
            $display("FAIL done_timeout: o_done=%b after %0d cycles, required 1", o_done, c);
        end else if (chk_lat && ($time - last_hs_t) != 10) begin
            n_fail++;
            $display("FAIL done_latency: %0t after tlast handshake, required 10", $time - last_hs_t);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL beats_missing: %0d expected beats left, required 0", exp_q.size());
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b0; i_num_records = '0; i_data = '0; i_data_vld = 1'b0; m_axis_tready = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_tests++;
        if ({m_axis_tvalid, m_axis_tlast, o_read, o_busy, o_done} !== 5'b0 || m_axis_tkeep !== '0 || m_axis_tdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b last=%b read=%b busy=%b done=%b keep=%h, required all 0",
                     m_axis_tvalid, m_axis_tlast, o_read, o_busy, o_done, m_axis_tkeep);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
    endtask

    task automatic test_full_beats();
        int cy;
        push_run(32, 0);
        do_start(32);
        n_tests++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b, required 1", o_busy);
        end
        feed(32, 0, 1'b0, 200, cy);
        n_tests++;
        if (cy != 32) begin
            n_fail++;
            $display("FAIL read_back_to_back: %0d cycles for 32 records, required 32", cy);
        end
        wait_done(1'b1);
    endtask

    task automatic test_partial();
        int cy;
        push_run(20, 0);
        do_start(20);
        feed(20, 0, 1'b0, 200, cy);
        wait_done(1'b1);
    endtask

    task automatic test_backpressure();
        int cy;
        push_run(48, 0);
        reads_cnt     = 0;
        m_axis_tready = 1'b0;
        do_start(48);
        fork
            feed(48, 0, 1'b0, 400, cy);
            begin
                beat_t cap;
                int    c = 0;
                bit    stable = 1'b1;
                @(posedge i_clk); #3;
                while (!m_axis_tvalid && c < 100) begin
                    @(posedge i_clk); #3;
                    c++;
                end
                n_tests++;
                if (!m_axis_tvalid) begin
                    n_fail++;
                    $display("FAIL bp_first_valid: tvalid=%b, required 1", m_axis_tvalid);
                end
                cap.d = m_axis_tdata; cap.k = m_axis_tkeep; cap.l = m_axis_tlast;
                repeat (40) begin
                    @(posedge i_clk); #3;
                    if (!m_axis_tvalid || m_axis_tdata !== cap.d || m_axis_tkeep !== cap.k || m_axis_tlast !== cap.l)
                        stable = 1'b0;
                end
                n_tests++;
                if (!stable) begin
                    n_fail++;
                    $display("FAIL bp_hold_stable: beat0 changed while stalled, required stable");
                end
                n_tests++;
                if (reads_cnt != 31 || o_read !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_stall: reads=%0d o_read=%b, required reads=31 o_read=0", reads_cnt, o_read);
                end
                m_axis_tready = 1'b1;
            end
        join
        wait_done(1'b1);
    endtask

    task automatic test_gappy();
        int cy;
        push_run(17, 200);
        do_start(17);
        feed(17, 200, 1'b1, 200, cy);
        wait_done(1'b1);
    endtask

    task automatic test_zero_and_ignored_start();
        int cy;
        int b0;
        b0 = n_tests;
        do_start(0);
        @(negedge i_clk);
        n_tests++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_done: got done=%b busy=%b, required done=1 busy=0", o_done, o_busy);
        end
        repeat (4) @(negedge i_clk);
        n_tests++;
        if (o_done !== 1'b0 || n_tests != b0 + 2) begin
            n_fail++;
            $display("FAIL zero_len_quiet: got done=%b extra beats=%0d, required done=0 no beats", o_done, n_tests - b0 - 2);
        end
        @(posedge i_clk); #1;
        push_run(20, 100);
        do_start(20);
        feed(5, 100, 1'b0, 50, cy);
        do_start(3);
        n_tests++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_run_busy: got %b, required 1", o_busy);
        end
        feed(15, 105, 1'b0, 100, cy);
        wait_done(1'b1);
    endtask

    task automatic test_reset_midrun();
        int cy;
        do_start(16);
        feed(7, 300, 1'b0, 50, cy);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst      = 1'b0;
        i_data_vld = 1'b1;
        @(negedge i_clk);
        n_tests++;
        if ({m_axis_tvalid, m_axis_tlast, o_read, o_busy, o_done} !== 5'b0 || m_axis_tkeep !== '0 || m_axis_tdata !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got valid=%b last=%b read=%b busy=%b done=%b, required all 0",
                     m_axis_tvalid, m_axis_tlast, o_read, o_busy, o_done);
        end
        @(posedge i_clk); #1;
        i_data_vld = 1'b0;
        push_run(16, 400);
        do_start(16);
        feed(16, 400, 1'b0, 100, cy);
        wait_done(1'b1);
    endtask

    initial begin
        test_reset();
        test_full_beats();
        test_partial();
        test_backpressure();
        test_gappy();
        test_zero_and_ignored_start();
        test_reset_midrun();
        repeat (3) @(posedge i_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
